ram_dp_init: RTL and testbench
==============================

Name: ram_dp_init

Overview:
- Parametrised true dual-port RAM; successor to the 2-port RAM.
- Adds per-byte write enables, selectable read-during-write mode and deterministic write-collision resolution.
- Adds an optional output register stage with read-valid strobes, and a hardware init FSM that clears the array after reset or on request.
- Single clock domain. Used as a shared scratch/buffer memory between two controllers.

Parameters:
- DEPTH, 256, number of words (need not be a power of 2).
- AWID, 8, address width; must satisfy 2**AWID >= DEPTH.
- DWID, 16, data width; must be a multiple of 8.
- BEWID, DWID/8, byte-enable width (derived).
- RDW_MODE, 0, same-port read-during-write: 0 = old data (read-first), 1 = new data (write-first).
- OUT_REG, 1, 0 = read latency 1, 1 = read latency 2 (extra output register).
- INIT_VAL, 0, DWID-bit value written to every word by the init FSM.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst_n  in  1  asynchronous active-low reset.
- init_req  in  1  1-cycle pulse; restarts array clear.
- busy  out  1  high while reset or init is in progress; port accesses are ignored.
- a_en  in  1  port A access enable.
- a_we  in  1  port A write (valid when a_en=1).
- a_be  in  BEWID  port A byte enables.
- a_addr  in  AWID  port A address.
- a_din  in  DWID  port A write data.
- a_dout  out  DWID  port A read data.
- a_vld  out  1  port A read data valid, 1-cycle pulse.
- b_en, b_we, b_be, b_addr, b_din, b_dout, b_vld: same as port A, for port B.
- coll  out  1  1-cycle pulse: both ports wrote the same address.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to INIT with counter 0; busy=1.
  - a_dout, b_dout, a_vld, b_vld and coll all go to 0.
  - The memory array itself has no reset.
- FSM states:
  - INIT: writes INIT_VAL to address = counter each cycle, counter += 1. When counter = DEPTH-1 is written, go to RUN next cycle. INIT lasts exactly DEPTH cycles after rst_n rises.
  - RUN: busy=0. init_req=1 returns to INIT with counter 0.
  - init_req during INIT restarts the counter at 0.
  - rst_n asserted mid-INIT restarts INIT from 0 after release.
- While busy=1:
  - a_en and b_en are masked: no user writes, no vld pulses, dout holds.
  - coll stays 0.
- Access is accepted when en=1 in RUN.
  - A write updates only the bytes whose be bit is 1; be=0 with we=1 writes nothing.
  - Every accepted access (read or write) returns read data.
- Read latency:
  - OUT_REG=0: data and vld appear 1 cycle after the accepted access.
  - OUT_REG=1: data and vld appear 2 cycles after it.
  - dout holds its last value when vld=0.
  - Back-to-back accesses give back-to-back vld with no bubbles.
- Same-port read-during-write: the port returns old data when RDW_MODE=0; it returns merged new data when RDW_MODE=1.
- Cross-port: one port writes X while the other reads X in the same cycle. The reader always gets the old data, independent of RDW_MODE.
- Both ports write the same address in the same cycle:
  - Result is a per-byte merge; on overlapping bytes port A wins.
  - coll pulses for 1 cycle, one cycle after the access, whether or not the bytes overlap.
- Address >= DEPTH:
  - A write is dropped.
  - A read returns all zeros with vld still asserted.
  - coll is never raised for out-of-range addresses.

Decomposition:
- Package ram_dp_pkg holds:
  - typedef enum logic {ST_INIT, ST_RUN} state_e;
  - typedef enum bit {RDW_OLD=0, RDW_NEW=1} rdw_mode_e;
  - function to compute byte-merge and collision.
- Sub-module ram_dp_rdpipe: per-port read-data/vld pipeline of depth 1 or 2 (per OUT_REG), async active-low reset. Instantiated twice.
- Array storage, collision merge and the init FSM stay in the top module.

Test Plan:
1. Release rst_n (default params): busy=1 for exactly 256 cycles, then 0. A reads 0x55 → a_vld 2 cycles later, a_dout=0x0000.
2. Byte enables:
   - A writes addr 3, 0xABCD, be=11; then addr 3, 0x1234, be=01.
   - A reads addr 3 → 0xAB34.
   - With OUT_REG=0, vld arrives 1 cycle after the read; with OUT_REG=1, 2 cycles after.
3. Read-during-write:
   - Setup: addr 7 holds 0x1111. A writes 0x5A5A to addr 7 while B reads addr 7 in the same cycle.
   - a_dout=0x1111 when RDW_MODE=0; a_dout=0x5A5A when RDW_MODE=1.
   - b_dout=0x1111 in both modes.
4. Collision:
   - A writes 0xAAAA be=11 and B writes 0xBBBB be=11 to addr 9 → coll pulses once; readback 0xAAAA.
   - Repeat with A be=10, B be=01 → coll pulses; readback 0xAABB.
5. Mid-operation reinit:
   - Write addr 5=0x7777, then pulse init_req → busy for 256 cycles. Read addr 5 → 0x0000.
   - rst_n at init count 100 → outputs 0; busy lasts a full 256 cycles after release.
6. Masking and range:
   - a_en/a_we pulsed during INIT → no a_vld, no write.
   - With DEPTH=200: write addr 250 is dropped; read addr 250 → vld=1, data 0.

Source files
------------

// File: rtl/ram_dp_pkg.sv
// Shared types and helpers for the dual-port RAM with hardware init.
// The byte-merge helper works on a maximum-width word so it can be used
// by any instance; callers zero-extend their operands and truncate the result.
package ram_dp_pkg;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    typedef enum bit {RDW_OLD = 1'b0, RDW_NEW = 1'b1} rdw_mode_e;

    localparam int MAX_DWID  = 512;
    localparam int MAX_BEWID = MAX_DWID / 8;
    localparam int MAX_AWID  = 32;

    // Replace the bytes of old_word selected by be with the bytes of new_word.
    function automatic logic [MAX_DWID-1:0] byte_merge(
        input logic [MAX_DWID-1:0]  old_word,
        input logic [MAX_DWID-1:0]  new_word,
        input logic [MAX_BEWID-1:0] be
    );
        logic [MAX_DWID-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BEWID; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Both ports write the same (in-range) address in the same cycle.
    function automatic logic write_collision(
        input logic                a_wr,
        input logic                b_wr,
        input logic [MAX_AWID-1:0] a_addr,
        input logic [MAX_AWID-1:0] b_addr
    );
        return a_wr & b_wr & (a_addr == b_addr);
    endfunction

endpackage

// File: rtl/ram_dp_rdpipe.sv
// Per-port read-data / valid pipeline, one or two register stages deep.
// dout only updates when a valid word moves into the output stage, so it
// holds its last value whenever vld is low.
module ram_dp_rdpipe #(
    parameter int DWID    = 16,
    parameter int OUT_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            acc,
    input  logic [DWID-1:0] rd_data,
    output logic [DWID-1:0] dout,
    output logic            vld
);

    logic [DWID-1:0] d1_r;
    logic            v1_r;

    // First stage: capture the array read for every accepted access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_r <= '0;
            v1_r <= 1'b0;
        end else begin
            v1_r <= acc;
            if (acc) begin
                d1_r <= rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_two_stage
            logic [DWID-1:0] d2_r;
            logic            v2_r;

            // Second stage: extra output register for timing closure.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d2_r <= '0;
                    v2_r <= 1'b0;
                end else begin
                    v2_r <= v1_r;
                    if (v1_r) begin
                        d2_r <= d1_r;
                    end
                end
            end

            assign dout = d2_r;
            assign vld  = v2_r;
        end else begin : g_one_stage
            assign dout = d1_r;
            assign vld  = v1_r;
        end
    endgenerate

endmodule

// File: rtl/ram_dp_init.sv
// True dual-port RAM with byte enables, selectable same-port read-during-write,
// port-A-wins collision merge, optional output register and a clear-on-reset /
// clear-on-request init FSM. Out-of-range writes are dropped and out-of-range
// reads return zero.
module ram_dp_init
    import ram_dp_pkg::*;
#(
    parameter int              DEPTH    = 256,
    parameter int              AWID     = 8,
    parameter int              DWID     = 16,
    localparam int             BEWID    = DWID / 8,
    parameter int              RDW_MODE = 0,
    parameter int              OUT_REG  = 1,
    parameter logic [DWID-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_req,
    output logic             busy,
    input  logic             a_en,
    input  logic             a_we,
    input  logic [BEWID-1:0] a_be,
    input  logic [AWID-1:0]  a_addr,
    input  logic [DWID-1:0]  a_din,
    output logic [DWID-1:0]  a_dout,
    output logic             a_vld,
    input  logic             b_en,
    input  logic             b_we,
    input  logic [BEWID-1:0] b_be,
    input  logic [AWID-1:0]  b_addr,
    input  logic [DWID-1:0]  b_din,
    output logic [DWID-1:0]  b_dout,
    output logic             b_vld,
    output logic             coll
);

    localparam logic [AWID-1:0] CNT_LAST = AWID'(DEPTH - 1);
    localparam logic [31:0]     DEPTH_U  = 32'(DEPTH);

    logic [DWID-1:0] mem_r [DEPTH];

    state_e          state_r;
    state_e          state_nx_s;
    logic [AWID-1:0] cnt_r;
    logic [AWID-1:0] cnt_nx_s;
    logic            busy_r;
    logic            init_wr_s;
    logic            run_s;

    logic            a_acc_s, b_acc_s;
    logic            a_rng_s, b_rng_s;
    logic            a_wr_s, b_wr_s;
    logic            coll_s;
    logic            coll_r;
    logic [AWID-1:0] a_idx_s, b_idx_s;
    logic [DWID-1:0] a_old_s, b_old_s;
    logic [DWID-1:0] a_new_s, b_new_s, both_s;
    logic [DWID-1:0] a_wdata_s, b_wdata_s;
    logic [DWID-1:0] a_rd_s, b_rd_s;

    // FSM state, clear counter and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            busy_r  <= (state_nx_s == ST_INIT);
        end
    end

    // Next state: sweep every address once, restart on init_req.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                if (init_req) begin
                    state_nx_s = ST_INIT;
                    cnt_nx_s   = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_RUN;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_INIT;
                    cnt_nx_s   = cnt_r + AWID'(1);
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    state_nx_s = ST_INIT;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_RUN;
                    cnt_nx_s   = cnt_r;
                end
            end
            default: begin
                state_nx_s = ST_INIT;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // FSM outputs: init write strobe and user-port enable.
    always_comb begin
        init_wr_s = 1'b0;
        run_s     = 1'b0;
        case (state_r)
            ST_INIT: init_wr_s = 1'b1;
            ST_RUN:  run_s     = 1'b1;
            default: begin
                init_wr_s = 1'b0;
                run_s     = 1'b0;
            end
        endcase
    end

    // Port qualification, collision merge and read-data selection.
    always_comb begin
        a_acc_s = a_en & run_s;
        b_acc_s = b_en & run_s;
        a_rng_s = (32'(a_addr) < DEPTH_U);
        b_rng_s = (32'(b_addr) < DEPTH_U);
        a_wr_s  = a_acc_s & a_we & a_rng_s;
        b_wr_s  = b_acc_s & b_we & b_rng_s;
        a_idx_s = a_rng_s ? a_addr : '0;
        b_idx_s = b_rng_s ? b_addr : '0;
        coll_s  = write_collision(a_wr_s, b_wr_s, MAX_AWID'(a_addr), MAX_AWID'(b_addr));

        a_old_s = mem_r[a_idx_s];
        b_old_s = mem_r[b_idx_s];
        a_new_s = DWID'(byte_merge(MAX_DWID'(a_old_s), MAX_DWID'(a_din), MAX_BEWID'(a_be)));
        b_new_s = DWID'(byte_merge(MAX_DWID'(b_old_s), MAX_DWID'(b_din), MAX_BEWID'(b_be)));
        // On a collision both ports address the same word, so layer A over B.
        both_s  = DWID'(byte_merge(MAX_DWID'(b_new_s), MAX_DWID'(a_din), MAX_BEWID'(a_be)));

        a_wdata_s = coll_s ? both_s : a_new_s;
        b_wdata_s = coll_s ? both_s : b_new_s;

        // The cross-port reader always sees the pre-write array contents.
        if (!a_rng_s) begin
            a_rd_s = '0;
        end else if (a_wr_s && (RDW_MODE == int'(RDW_NEW))) begin
            a_rd_s = a_wdata_s;
        end else begin
            a_rd_s = a_old_s;
        end

        if (!b_rng_s) begin
            b_rd_s = '0;
        end else if (b_wr_s && (RDW_MODE == int'(RDW_NEW))) begin
            b_rd_s = b_wdata_s;
        end else begin
            b_rd_s = b_old_s;
        end
    end

    // Array writes: init sweep, else user writes (B suppressed on collision).
    always_ff @(posedge clk) begin
        if (init_wr_s) begin
            mem_r[cnt_r] <= INIT_VAL;
        end else begin
            if (a_wr_s) begin
                mem_r[a_idx_s] <= a_wdata_s;
            end
            if (b_wr_s && !coll_s) begin
                mem_r[b_idx_s] <= b_wdata_s;
            end
        end
    end

    // Collision flag, one-cycle pulse after the colliding access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_r <= 1'b0;
        end else begin
            coll_r <= coll_s;
        end
    end

    ram_dp_rdpipe #(
        .DWID    (DWID),
        .OUT_REG (OUT_REG)
    ) u_rdpipe_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc     (a_acc_s),
        .rd_data (a_rd_s),
        .dout    (a_dout),
        .vld     (a_vld)
    );

    ram_dp_rdpipe #(
        .DWID    (DWID),
        .OUT_REG (OUT_REG)
    ) u_rdpipe_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc     (b_acc_s),
        .rd_data (b_rd_s),
        .dout    (b_dout),
        .vld     (b_vld)
    );

    assign busy = busy_r;
    assign coll = coll_r;

endmodule

// File: tb/tb_ram_dp_init.sv
// Scoreboard bench for ram_dp_init. Two instances share the stimulus:
// dut0 uses defaults (DEPTH 256, read-first, latency 2), dut1 uses
// DEPTH 200, write-first, latency 1. Expected words and arrival cycles are
// queued at issue time and popped by a monitor on the falling edge.
module tb_ram_dp_init;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_req;
    logic        a_en, a_we, b_en, b_we;
    logic [1:0]  a_be, b_be;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;

    logic        busy0, a_vld0, b_vld0, coll0;
    logic [15:0] a_dout0, b_dout0;
    logic        busy1, a_vld1, b_vld1, coll1;
    logic [15:0] a_dout1, b_dout1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q0a[$], q0b[$], q1a[$], q1b[$];
    int   qc0[$], qc1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ram_dp_init u_dut0 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy0),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout0), .a_vld(a_vld0),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout0), .b_vld(b_vld0), .coll(coll0)
    );

    ram_dp_init #(
        .DEPTH(200), .AWID(8), .DWID(16), .RDW_MODE(1), .OUT_REG(0), .INIT_VAL(16'h0000)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy1),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout1), .a_vld(a_vld1),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout1), .b_vld(b_vld1), .coll(coll1)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a DUT presents data or a collision.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (a_vld0) begin
            if (q0a.size() == 0) cmp("dut0 A vld with nothing pending", a_vld0, 1'b0);
            else begin e = q0a.pop_front(); cmp("dut0 A data", a_dout0, e.data); cmp("dut0 A cycle", cyc, e.cyc); end
        end else if (q0a.size() != 0 && q0a[0].cyc < cyc) begin
            cmp("dut0 A missing vld", a_vld0, 1'b1); void'(q0a.pop_front());
        end
        if (b_vld0) begin
            if (q0b.size() == 0) cmp("dut0 B vld with nothing pending", b_vld0, 1'b0);
            else begin e = q0b.pop_front(); cmp("dut0 B data", b_dout0, e.data); cmp("dut0 B cycle", cyc, e.cyc); end
        end else if (q0b.size() != 0 && q0b[0].cyc < cyc) begin
            cmp("dut0 B missing vld", b_vld0, 1'b1); void'(q0b.pop_front());
        end
        if (a_vld1) begin
            if (q1a.size() == 0) cmp("dut1 A vld with nothing pending", a_vld1, 1'b0);
            else begin e = q1a.pop_front(); cmp("dut1 A data", a_dout1, e.data); cmp("dut1 A cycle", cyc, e.cyc); end
        end else if (q1a.size() != 0 && q1a[0].cyc < cyc) begin
            cmp("dut1 A missing vld", a_vld1, 1'b1); void'(q1a.pop_front());
        end
        if (b_vld1) begin
            if (q1b.size() == 0) cmp("dut1 B vld with nothing pending", b_vld1, 1'b0);
            else begin e = q1b.pop_front(); cmp("dut1 B data", b_dout1, e.data); cmp("dut1 B cycle", cyc, e.cyc); end
        end else if (q1b.size() != 0 && q1b[0].cyc < cyc) begin
            cmp("dut1 B missing vld", b_vld1, 1'b1); void'(q1b.pop_front());
        end
        if (coll0) begin
            if (qc0.size() == 0) cmp("dut0 unexpected coll", coll0, 1'b0);
            else cmp("dut0 coll cycle", cyc, qc0.pop_front());
        end else if (qc0.size() != 0 && qc0[0] < cyc) begin
            cmp("dut0 missing coll", coll0, 1'b1); void'(qc0.pop_front());
        end
        if (coll1) begin
            if (qc1.size() == 0) cmp("dut1 unexpected coll", coll1, 1'b0);
            else cmp("dut1 coll cycle", cyc, qc1.pop_front());
        end else if (qc1.size() != 0 && qc1[0] < cyc) begin
            cmp("dut1 missing coll", coll1, 1'b1); void'(qc1.pop_front());
        end
    end

    // Drive one cycle of port activity (called on a falling edge) and queue
    // the expected read data for each instance: dut0 latency 2, dut1 latency 1.
    task automatic acc(
        input logic ae, input logic aw, input logic [1:0] abe, input logic [7:0] aad,
        input logic [15:0] adi, input logic [15:0] ea0, input logic [15:0] ea1,
        input logic be_, input logic bw, input logic [1:0] bbe, input logic [7:0] bad,
        input logic [15:0] bdi, input logic [15:0] eb0, input logic [15:0] eb1,
        input logic ec0, input logic ec1
    );
        a_en = ae;  a_we = aw; a_be = abe; a_addr = aad; a_din = adi;
        b_en = be_; b_we = bw; b_be = bbe; b_addr = bad; b_din = bdi;
        if (ae) begin
            q0a.push_back('{ea0, cyc + 2});
            q1a.push_back('{ea1, cyc + 1});
        end
        if (be_) begin
            q0b.push_back('{eb0, cyc + 2});
            q1b.push_back('{eb1, cyc + 1});
        end
        if (ec0) qc0.push_back(cyc + 1);
        if (ec1) qc1.push_back(cyc + 1);
        @(negedge clk);
    endtask

    task automatic rd_a(input logic [7:0] ad, input logic [15:0] e0, input logic [15:0] e1);
        acc(1'b1, 1'b0, 2'b00, ad, 16'h0000, e0, e1,
            1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic rd_b(input logic [7:0] ad, input logic [15:0] e0, input logic [15:0] e1);
        acc(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 16'h0000, 16'h0000,
            1'b1, 1'b0, 2'b00, ad, 16'h0000, e0, e1, 1'b0, 1'b0);
    endtask

    task automatic wr_a(input logic [7:0] ad, input logic [15:0] d, input logic [1:0] be,
                        input logic [15:0] e0, input logic [15:0] e1);
        acc(1'b1, 1'b1, be, ad, d, e0, e1,
            1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Count busy cycles of both instances; optionally poke port A mid-init.
    task automatic wait_init(input int exp0, input int exp1, input bit poke);
        int n0;
        int n1;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy0 && !busy1) break;
            if (busy0) n0++;
            if (busy1) n1++;
            if (poke && i == 150) begin
                a_en = 1'b1; a_we = 1'b1; a_be = 2'b11; a_addr = 8'h00; a_din = 16'hDEAD;
            end
            if (poke && i == 151) begin
                a_en = 1'b0; a_we = 1'b0;
            end
            @(negedge clk);
        end
        cmp("dut0 busy cycles", n0, exp0);
        cmp("dut1 busy cycles", n1, exp1);
    endtask

    initial begin
        rst_n = 1'b0; init_req = 1'b0;
        a_en = 1'b0; a_we = 1'b0; a_be = 2'b00; a_addr = 8'h00; a_din = 16'h0000;
        b_en = 1'b0; b_we = 1'b0; b_be = 2'b00; b_addr = 8'h00; b_din = 16'h0000;
        repeat (3) @(negedge clk);

        // Reset state
        cmp("reset busy0", busy0, 1'b1);
        cmp("reset busy1", busy1, 1'b1);
        cmp("reset a_dout0", a_dout0, 16'h0000);
        cmp("reset a_vld0", a_vld0, 1'b0);
        cmp("reset coll0", coll0, 1'b0);
        cmp("reset b_dout1", b_dout1, 16'h0000);

        // Release reset: init sweep length, masked write during init
        rst_n = 1'b1;
        wait_init(256, 200, 1'b1);
        rd_a(8'h55, 16'h0000, 16'h0000);
        rd_a(8'h00, 16'h0000, 16'h0000);

        // Byte enables
        wr_a(8'h03, 16'hABCD, 2'b11, 16'h0000, 16'hABCD);
        wr_a(8'h03, 16'h1234, 2'b01, 16'hABCD, 16'hAB34);
        rd_a(8'h03, 16'hAB34, 16'hAB34);
        idle(1);

        // Read-during-write: same port follows RDW_MODE, other port sees old
        wr_a(8'h07, 16'h1111, 2'b11, 16'h0000, 16'h1111);
        idle(1);
        acc(1'b1, 1'b1, 2'b11, 8'h07, 16'h5A5A, 16'h1111, 16'h5A5A,
            1'b1, 1'b0, 2'b00, 8'h07, 16'h0000, 16'h1111, 16'h1111, 1'b0, 1'b0);
        rd_a(8'h07, 16'h5A5A, 16'h5A5A);
        idle(1);

        // Collisions: full overlap, then disjoint bytes
        acc(1'b1, 1'b1, 2'b11, 8'h09, 16'hAAAA, 16'h0000, 16'hAAAA,
            1'b1, 1'b1, 2'b11, 8'h09, 16'hBBBB, 16'h0000, 16'hAAAA, 1'b1, 1'b1);
        rd_a(8'h09, 16'hAAAA, 16'hAAAA);
        acc(1'b1, 1'b1, 2'b10, 8'h09, 16'hAAAA, 16'hAAAA, 16'hAABB,
            1'b1, 1'b1, 2'b01, 8'h09, 16'hBBBB, 16'hAAAA, 16'hAABB, 1'b1, 1'b1);
        rd_b(8'h09, 16'hAABB, 16'hAABB);
        wr_a(8'h0A, 16'hFFFF, 2'b00, 16'h0000, 16'h0000);
        rd_a(8'h0A, 16'h0000, 16'h0000);
        idle(1);

        // Address 250: in range for dut0, out of range for dut1
        acc(1'b1, 1'b1, 2'b11, 8'd250, 16'hBEEF, 16'h0000, 16'h0000,
            1'b1, 1'b1, 2'b01, 8'd250, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0);
        rd_a(8'd250, 16'hBEEF, 16'h0000);
        rd_b(8'd250, 16'hBEEF, 16'h0000);
        idle(3);

        // init_req clears the array; dout holds while busy
        wr_a(8'h05, 16'h7777, 2'b11, 16'h0000, 16'h7777);
        rd_a(8'h05, 16'h7777, 16'h7777);
        idle(3);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        cmp("dut0 dout held during init", a_dout0, 16'h7777);
        wait_init(256, 200, 1'b0);
        rd_a(8'h05, 16'h0000, 16'h0000);
        idle(1);

        // Reset in the middle of an init sweep
        wr_a(8'h06, 16'h4242, 2'b11, 16'h0000, 16'h4242);
        rd_a(8'h06, 16'h4242, 16'h4242);
        idle(3);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp("mid-init reset a_dout0", a_dout0, 16'h0000);
        cmp("mid-init reset a_dout1", a_dout1, 16'h0000);
        cmp("mid-init reset busy0", busy0, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init(256, 200, 1'b0);
        rd_a(8'h06, 16'h0000, 16'h0000);
        idle(4);

        cmp("pending reads left", q0a.size() + q0b.size() + q1a.size() + q1b.size(), 0);
        cmp("pending collisions left", qc0.size() + qc1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
